// File: rtl/cmd_parser_pkg.sv
// Shared constants, state encoding and MREQ layout for the host command parser.
package cmd_parser_pkg;

  localparam logic [7:0] CMD_SYNC_BYTE = 8'hA5;
  localparam int         CMD_HDR_LEN   = 7;

  localparam int FLAG_WR_BIT    = 7;
  localparam int FLAG_AINCR_BIT = 6;
  localparam int FLAG_WFMT_MSB  = 2;
  localparam int FLAG_WFMT_LSB  = 0;

  localparam int MREQ_NBIT = 45;

  localparam logic [2:0] MREQ_WFMT_8  = 3'd0;
  localparam logic [2:0] MREQ_WFMT_16 = 3'd1;
  localparam logic [2:0] MREQ_WFMT_32 = 3'd2;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_HDR   = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic        wr;
    logic        aincr;
    logic [2:0]  wfmt;
    logic [7:0]  wcnt;
    logic [23:0] addr;
  } mreq_t;

  function automatic mreq_t pack_mreq(input logic [7:0]  tag,
                                      input logic        wr,
                                      input logic        aincr,
                                      input logic [2:0]  wfmt,
                                      input logic [7:0]  wcnt,
                                      input logic [23:0] addr);
    mreq_t m;
    m.tag   = tag;
    m.wr    = wr;
    m.aincr = aincr;
    m.wfmt  = wfmt;
    m.wcnt  = wcnt;
    m.addr  = addr;
    return m;
  endfunction

endpackage

// File: rtl/cmd_parser.sv
// Frames the host byte stream into MREQ headers and holds each until cmd_wb completes.
// CSUM accepted at N -> o_mreq_valid at N+1; reads stall the host, writes pass payload through.
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_ready,
  output logic                 o_rx_valid,
  output logic [7:0]           o_rx_data,
  input  logic                 i_rx_ready,
  output logic                 o_mreq_valid,
  input  logic                 i_mreq_ready,
  output logic [MREQ_NBIT-1:0] o_mreq,
  output logic                 o_err_csum,
  output logic                 o_err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    LAST_IDX = 3'(CMD_HDR_LEN - 1);

  state_t        state, state_nxt;
  logic [2:0]    ctr;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    hdr [6];
  mreq_t         mreq_q;
  logic [7:0]    csum_calc;
  logic          accept, load_mreq, csum_bad, tmo_hit;

  assign o_mreq    = mreq_q;
  assign csum_calc = hdr[0] ^ hdr[1] ^ hdr[2] ^ hdr[3] ^ hdr[4] ^ hdr[5];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_rx_ready = 1'b0;
    o_rx_valid = 1'b0;
    o_rx_data  = 8'h00;
    accept     = 1'b0;
    load_mreq  = 1'b0;
    csum_bad   = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state)
      ST_SYNC: begin
        o_rx_ready = 1'b1;
        accept     = i_rx_valid;
        if (i_rx_valid && i_rx_data == CMD_SYNC_BYTE) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        o_rx_ready = 1'b1;
        accept     = i_rx_valid;
        if (i_rx_valid) begin
          if (ctr == LAST_IDX) begin
            if (i_rx_data == csum_calc) begin
              load_mreq = 1'b1;
              state_nxt = ST_ISSUE;
            end else begin
              csum_bad  = 1'b1;
              state_nxt = ST_SYNC;
            end
          end
        end else if (TIMEOUT_CYCLES > 0 && tmo_cnt == TMO_LAST) begin
          // this idle cycle is the TIMEOUT_CYCLES-th in a row
          tmo_hit   = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      ST_ISSUE: begin
        if (mreq_q.wr) begin
          o_rx_valid = i_rx_valid;
          o_rx_data  = i_rx_data;
          o_rx_ready = i_rx_ready;
        end
        if (i_mreq_ready) state_nxt = ST_SYNC;
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr           <= '0;
      tmo_cnt       <= '0;
      mreq_q        <= '0;
      o_mreq_valid  <= 1'b0;
      o_err_csum    <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      o_err_csum    <= csum_bad;
      o_err_timeout <= tmo_hit;
      if (state != ST_HDR) begin
        ctr     <= '0;
        tmo_cnt <= '0;
      end else if (accept) begin
        ctr     <= ctr + 3'd1;
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_SAT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (load_mreq) begin
        mreq_q       <= pack_mreq(hdr[0], hdr[1][FLAG_WR_BIT], hdr[1][FLAG_AINCR_BIT],
                                  hdr[1][FLAG_WFMT_MSB:FLAG_WFMT_LSB], hdr[2],
                                  {hdr[5], hdr[4], hdr[3]});
        o_mreq_valid <= 1'b1;
      end else if (state == ST_ISSUE && i_mreq_ready) begin
        o_mreq_valid <= 1'b0;
      end
    end
  end

  // header bytes TAG..ADDR2; the CSUM byte is compared on the fly, never stored
  always_ff @(posedge clk) begin
    if (state == ST_HDR && accept && ctr < LAST_IDX) hdr[ctr] <= i_rx_data;
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized scoreboard bench for cmd_parser: host driver, cmd_wb responder and monitor run independently.
module tb_cmd_parser;
  import cmd_parser_pkg::*;

  localparam int TMO     = 16;
  localparam int EV_CSUM = 1;
  localparam int EV_TMO  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_rx_valid;
  logic [7:0]           i_rx_data;
  logic                 o_rx_ready;
  logic                 o_rx_valid;
  logic [7:0]           o_rx_data;
  logic                 i_rx_ready;
  logic                 o_mreq_valid;
  logic                 i_mreq_ready;
  logic [MREQ_NBIT-1:0] o_mreq;
  logic                 o_err_csum;
  logic                 o_err_timeout;

  cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_ready(i_rx_ready),
    .o_mreq_valid(o_mreq_valid), .i_mreq_ready(i_mreq_ready), .o_mreq(o_mreq),
    .o_err_csum(o_err_csum), .o_err_timeout(o_err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [MREQ_NBIT-1:0] exp_mreq[$];
  logic [7:0]           exp_payload[$];
  int                   exp_evt[$];
  int                   wb_len_q[$];
  logic [7:0]           pay_fixed[$];
  int                   hold_len = -1;
  bit                   mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // host side: optional idle gap, then hold the byte until o_rx_ready
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit hs;
    int waited;
    hs = 0;
    waited = 0;
    repeat (gap) begin
      @(negedge clk);
      i_rx_valid = 1'b0;
    end
    while (!hs && waited < 2000) begin
      @(negedge clk);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      #1 hs = o_rx_ready;
      @(posedge clk);
      waited++;
    end
    #1 i_rx_valid = 1'b0;
    if (!hs) chk("host_byte_accepted", {63'd0, hs}, 64'd1);
  endtask

  function automatic int rgap();
    return int'($urandom_range(0, 3));
  endfunction

  task automatic do_frame(input logic [7:0] tag, input logic [7:0] flags, input logic [7:0] wcnt,
                          input logic [23:0] addr, input logic [7:0] flip, input int npay,
                          input int gap_idx, input int gap_len);
    logic [7:0] b [8];
    logic [7:0] p;
    b[0] = 8'hA5; b[1] = tag; b[2] = flags; b[3] = wcnt;
    b[4] = addr[7:0]; b[5] = addr[15:8]; b[6] = addr[23:16];
    b[7] = tag ^ flags ^ wcnt ^ addr[7:0] ^ addr[15:8] ^ addr[23:16] ^ flip;
    if (flip == 8'h00) begin
      exp_mreq.push_back({tag, flags[7], flags[6], flags[2:0], wcnt, addr});
      wb_len_q.push_back(hold_len >= 0 ? hold_len : (flags[7] ? npay : 0));
    end else begin
      exp_evt.push_back(EV_CSUM);
    end
    for (int i = 0; i < 8; i++) send_byte(b[i], (i == gap_idx) ? gap_len : rgap());
    if (flip == 8'h00 && flags[7]) begin
      for (int i = 0; i < npay; i++) begin
        p = (pay_fixed.size() > 0) ? pay_fixed.pop_front() : 8'($urandom);
        exp_payload.push_back(p);
        send_byte(p, rgap());
      end
    end
  endtask

  task automatic do_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, rgap());
    end
  endtask

  task automatic do_timeout();
    exp_evt.push_back(EV_TMO);
    send_byte(8'hA5, rgap());
    send_byte(8'($urandom), rgap());
    repeat (TMO) @(negedge clk);
  endtask

  // cmd_wb model: takes the announced payload length, drains it with random stalls, then completes
  initial begin
    bit rdy;
    bit active;
    int cnt, len, dly;
    active = 0; cnt = 0; len = 0; dly = 0;
    i_rx_ready   = 1'b0;
    i_mreq_ready = 1'b0;
    forever begin
      @(negedge clk);
      i_mreq_ready = 1'b0;
      if (active && !o_mreq_valid) active = 0;
      if (!active && o_mreq_valid === 1'b1) begin
        active = 1;
        cnt    = 0;
        len    = (wb_len_q.size() > 0) ? wb_len_q.pop_front() : 0;
        dly    = int'($urandom_range(0, 4));
      end
      rdy = 0;
      if (active) begin
        if (cnt >= len) begin
          if (dly == 0) begin
            i_mreq_ready = 1'b1;
            active = 0;
          end else dly--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
      i_rx_ready = rdy;
      #1 if (rdy && o_rx_valid) cnt++;
    end
  end

  // monitor: compares everything the DUT presents against the queued expectations
  initial begin
    bit mreq_seen, prev_csum, prev_tmo;
    logic [MREQ_NBIT-1:0] last_mreq;
    mreq_seen = 0; prev_csum = 0; prev_tmo = 0; last_mreq = '0;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (o_rx_valid) chk("rx_valid_only_in_issue", {63'd0, o_mreq_valid}, 64'd1);
        if (o_rx_valid && i_rx_ready) begin
          chk("payload_expected", {63'd0, exp_payload.size() > 0}, 64'd1);
          if (exp_payload.size() > 0) chk("payload_byte", {56'd0, o_rx_data}, {56'd0, exp_payload.pop_front()});
        end
        if (o_mreq_valid) begin
          if (!mreq_seen) begin
            chk("mreq_expected", {63'd0, exp_mreq.size() > 0}, 64'd1);
            if (exp_mreq.size() > 0) chk("mreq_fields", 64'(o_mreq), 64'(exp_mreq.pop_front()));
            mreq_seen = 1;
            last_mreq = o_mreq;
          end else begin
            chk("mreq_stable", 64'(o_mreq), 64'(last_mreq));
          end
          if (!last_mreq[36]) chk("read_holds_host", {62'd0, o_rx_ready, o_rx_valid}, 64'd0);
        end else begin
          mreq_seen = 0;
        end
        if (o_err_csum) begin
          chk("csum_pulse_width", {63'd0, prev_csum}, 64'd0);
          chk("csum_err_expected", {63'd0, exp_evt.size() > 0}, 64'd1);
          if (exp_evt.size() > 0) chk("csum_err_kind", 64'(exp_evt.pop_front()), 64'(EV_CSUM));
        end
        if (o_err_timeout) begin
          chk("tmo_pulse_width", {63'd0, prev_tmo}, 64'd0);
          chk("tmo_err_expected", {63'd0, exp_evt.size() > 0}, 64'd1);
          if (exp_evt.size() > 0) chk("tmo_err_kind", 64'(exp_evt.pop_front()), 64'(EV_TMO));
        end
        prev_csum = o_err_csum;
        prev_tmo  = o_err_timeout;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  tg, fl, wc;
    logic [23:0] ad;
    int          k, w;
    rst = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mreq_valid", {63'd0, o_mreq_valid}, 64'd0);
    chk("rst_mreq",       64'(o_mreq), 64'd0);
    chk("rst_err_csum",   {63'd0, o_err_csum}, 64'd0);
    chk("rst_err_tmo",    {63'd0, o_err_timeout}, 64'd0);
    chk("rst_rx_valid",   {63'd0, o_rx_valid}, 64'd0);
    chk("rst_rx_ready",   {63'd0, o_rx_ready}, 64'd1);
    mon_en = 1;

    // write with fixed payload, then a read with more bytes queued behind it
    pay_fixed = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_frame(8'h01, 8'hC2, 8'h00, 24'h000010, 8'h00, 4, -1, 0);
    do_frame(8'h07, 8'h40, 8'h03, 24'h000100, 8'h00, 0, -1, 0);
    do_garbage(3);
    do_frame(8'h22, 8'h81, 8'h05, 24'hA5A5A5, 8'h00, 2, -1, 0);
    // bad checksum followed by a good frame
    do_frame(8'h10, 8'h00, 8'h01, 24'h000020, 8'h01, 0, -1, 0);
    do_frame(8'h11, 8'h02, 8'h01, 24'h000030, 8'h00, 0, -1, 0);
    // timeout boundary: 16 idle cycles drops the header, 15 does not
    do_timeout();
    do_frame(8'h33, 8'h05, 8'h01, 24'h123456, 8'h00, 0, 2, TMO - 1);

    for (int t = 0; t < 40; t++) begin
      k  = int'($urandom_range(0, 9));
      tg = 8'($urandom); fl = 8'($urandom); wc = 8'($urandom); ad = 24'($urandom);
      if (k <= 3) begin
        fl[7] = 1'b1;
        do_frame(tg, fl, wc, ad, 8'h00, int'($urandom_range(0, 6)), -1, 0);
      end else if (k <= 5) begin
        fl[7] = 1'b0;
        do_frame(tg, fl, wc, ad, 8'h00, 0, -1, 0);
      end else if (k == 6) begin
        do_garbage(int'($urandom_range(1, 3)));
      end else if (k <= 8) begin
        do_frame(tg, fl, wc, ad, 8'($urandom_range(1, 255)), 0, -1, 0);
      end else begin
        do_timeout();
      end
    end

    // reset while a read is being issued
    hold_len = 1000;
    do_frame(8'h5C, 8'h49, 8'h02, 24'hABCDEF, 8'h00, 0, -1, 0);
    hold_len = -1;
    w = 0;
    while (!o_mreq_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("issue_before_reset", {63'd0, o_mreq_valid}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_issue_valid", {63'd0, o_mreq_valid}, 64'd0);
    chk("rst_mid_issue_mreq",  64'(o_mreq), 64'd0);
    chk("rst_mid_issue_sync",  {63'd0, o_rx_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    do_frame(8'h66, 8'hC1, 8'h01, 24'h000777, 8'h00, 3, -1, 0);

    w = 0;
    while ((exp_mreq.size() + exp_payload.size() + exp_evt.size() > 0 || o_mreq_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    chk("leftover_mreq",    64'(exp_mreq.size()), 64'd0);
    chk("leftover_payload", 64'(exp_payload.size()), 64'd0);
    chk("leftover_events",  64'(exp_evt.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
